// File: rtl/axi_defs_pkg.sv
// Shared definitions for the uncached write buffer.
// Contents:
//   BURST_INCR, SIZE_WORD, RESP_OKAY : AXI field encodings used by the buffer
//   wbuf_entry_t                     : one buffered store (address, data, strobes, size)
//   wbuf_state_t                     : AXI issue FSM states
package axi_defs_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'd2;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  size;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT_B = 2'd2
    } wbuf_state_t;

endpackage

// File: rtl/uncached_write_buffer_if.sv
// AXI write-channel bundle (AW, W, B) between the write buffer and the bus.
// Modports:
//   master : the write buffer; drives AW/W payload and valids plus bready
//   slave  : the interconnect/memory; drives awready, wready and the B channel
interface uncached_write_buffer_if;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/uncached_write_buffer_fifo.sv
// wbuf_fifo: storage for buffered stores with per-entry valid bits and a
// parallel word-address compare used for the load hazard check.
// Ports:
//   aclk, aresetn        : clock, asynchronous active-low reset
//   push, push_entry     : write push_entry at the write pointer (caller guarantees !full)
//   pop                  : retire the head entry (caller guarantees count != 0)
//   head                 : entry at the read pointer
//   count, full          : occupancy
//   chk_addr, chk_hit    : 1 when any valid entry matches chk_addr on bits [31:2]
module wbuf_fifo
    import axi_defs_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          push,
    input  wbuf_entry_t   push_entry,
    input  logic          pop,
    output wbuf_entry_t   head,
    output logic [CW-1:0] count,
    output logic          full,
    input  logic [31:0]   chk_addr,
    output logic          chk_hit
);

    wbuf_entry_t      mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Byte offset does not matter for the word-granular hazard check.
    logic unused_chk_lo;
    assign unused_chk_lo = ^chk_addr[1:0];

    // Payload storage needs no reset; the valid bits decide what is live.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. A push and a pop
    // in the same cycle never touch the same slot: pop needs count != 0 and
    // push needs !full, so wr_ptr != rd_ptr whenever both happen.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
    assign full = (count == CW'(DEPTH));

    // The in-flight head stays valid until its B response pops it, so loads to
    // that word keep stalling until the store has really completed.
    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (mem[i].addr[31:2] == chk_addr[31:2])) begin
                chk_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uncached_write_buffer.sv
// uncached_write_buffer: in-order store buffer that retires single-word cache
// stores as single-beat AXI writes, one transaction outstanding at a time.
// Ports:
//   aclk, aresetn                  : clock, asynchronous active-low reset
//   in_valid/in_ready, in_addr,
//   in_data, in_strb, in_size      : cache-side store request (in_ready = !full)
//   chk_addr, chk_hit              : load hazard check against all pending stores
//   empty, count                   : buffer drained / number of valid entries
//   bus_err                        : pulse in the cycle a B response with bresp != OKAY is taken
//   axi                            : AW/W/B channels (master side)
module uncached_write_buffer
    import axi_defs_pkg::*;
#(
    parameter  int         DEPTH  = 4,
    parameter  logic [3:0] AXI_ID = 4'd1,
    localparam int         CW     = $clog2(DEPTH) + 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_addr,
    input  logic [31:0]             in_data,
    input  logic [3:0]              in_strb,
    input  logic [2:0]              in_size,
    input  logic [31:0]             chk_addr,
    output logic                    chk_hit,
    output logic                    empty,
    output logic [CW-1:0]           count,
    output logic                    bus_err,
    uncached_write_buffer_if.master axi
);

    wbuf_state_t state, state_next;
    logic        aw_done, aw_done_next;
    logic        w_done, w_done_next;
    logic        push, pop, full;
    wbuf_entry_t head;

    // The B id carries no information with a single outstanding transaction.
    logic unused_bid;
    assign unused_bid = ^axi.bid;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .push       (push),
        .push_entry ('{addr: in_addr, data: in_data, strb: in_strb, size: in_size}),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .full       (full),
        .chk_addr   (chk_addr),
        .chk_hit    (chk_hit)
    );

    // The bus is one word wide, so a larger size code is clamped to a word.
    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = head.addr;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = (head.size > SIZE_WORD) ? SIZE_WORD : head.size;
    assign axi.awburst = BURST_INCR;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;
    assign axi.wid     = AXI_ID;
    assign axi.wdata   = head.data;
    assign axi.wstrb   = head.strb;
    assign axi.wlast   = 1'b1;

    assign empty = (count == '0) && (state == ST_IDLE);

    // State and handshake-progress flags; a reset abandons any transaction.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= ST_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_next;
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
        end
    end

    // AW and W are tracked independently so they can finish in either order;
    // each valid drops the cycle after its own handshake.
    always_comb begin
        state_next   = state;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        axi.awvalid  = 1'b0;
        axi.wvalid   = 1'b0;
        axi.bready   = 1'b0;
        pop          = 1'b0;
        bus_err      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                axi.awvalid = !aw_done;
                axi.wvalid  = !w_done;
                if (!aw_done && axi.awready) begin
                    aw_done_next = 1'b1;
                end
                if (!w_done && axi.wready) begin
                    w_done_next = 1'b1;
                end
                if (aw_done_next && w_done_next) begin
                    state_next   = ST_WAIT_B;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end
            end
            ST_WAIT_B: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    pop        = 1'b1;
                    bus_err    = (axi.bresp != RESP_OKAY);
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uncached_write_buffer.sv
// Self-checking bench for uncached_write_buffer: directed scenarios with
// literal expectations, then randomized traffic against a queue-based model.
module tb_uncached_write_buffer;
    import axi_defs_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_addr = '0;
    logic [31:0]   in_data = '0;
    logic [3:0]    in_strb = '0;
    logic [2:0]    in_size = '0;
    logic [31:0]   chk_addr = '0;
    logic          in_ready, chk_hit, empty, bus_err;
    logic [CW-1:0] count;

    uncached_write_buffer_if axi ();

    uncached_write_buffer #(.DEPTH(DEPTH), .AXI_ID(4'd1)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .in_strb  (in_strb),
        .in_size  (in_size),
        .chk_addr (chk_addr),
        .chk_hit  (chk_hit),
        .empty    (empty),
        .count    (count),
        .bus_err  (bus_err),
        .axi      (axi)
    );

    always #5 aclk = ~aclk;

    // Model of the buffer contents: the queue holds every accepted store that
    // has not yet received its B response, head first.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  size;
    } store_t;

    store_t      q[$];
    bit          aw_seen = 0, w_seen = 0, b_pending = 0;
    bit          prev_aw_stall = 0, prev_w_stall = 0;
    logic [31:0] prev_awaddr = '0, prev_wdata = '0;
    int          pops = 0, aw_total = 0, w_total = 0;
    int          checks = 0, failures = 0;

    // Slave behaviour selected by the stimulus process, applied each cycle.
    logic        slv_awready = 1'b1, slv_wready = 1'b1, slv_bv_en = 1'b1;
    logic [1:0]  slv_bresp = 2'b00;
    int          err_at = -1;
    logic [31:0] next_chk = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of cache-side and slave-side inputs just after the edge.
    task automatic applyStimulus(input logic iv, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input logic [2:0] sz);
        @(posedge aclk);
        #1;
        in_valid    = iv;
        in_addr     = a;
        in_data     = d;
        in_strb     = s;
        in_size     = sz;
        chk_addr    = next_chk;
        axi.awready = slv_awready;
        axi.wready  = slv_wready;
        axi.bvalid  = slv_bv_en && b_pending;
        axi.bresp   = (pops == err_at) ? 2'b10 : slv_bresp;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
    endtask

    task automatic waitEmpty(input int budget, input string name);
        int n;
        n = 0;
        while (n < budget) begin
            idleCycle();
            @(negedge aclk);
            if (empty === 1'b1 && q.size() == 0) break;
            n++;
        end
        checkOutput(name, 32'(empty), 32'h1);
    endtask

    // Compare process: checks every output against the model each cycle, then
    // advances the model with the handshakes that the next rising edge takes.
    always @(negedge aclk) begin : compare
        bit can_push, hit, b_hs;
        if (!aresetn) begin
            q.delete();
            aw_seen       = 0;
            w_seen        = 0;
            b_pending     = 0;
            prev_aw_stall = 0;
            prev_w_stall  = 0;
        end else begin
            can_push = (q.size() < DEPTH);
            checkOutput("in_ready", 32'(in_ready), 32'(can_push));
            checkOutput("count", 32'(count), 32'(q.size()));
            checkOutput("empty", 32'(empty), 32'(q.size() == 0));
            hit = 0;
            foreach (q[i]) if (q[i].addr[31:2] == chk_addr[31:2]) hit = 1;
            checkOutput("chk_hit", 32'(chk_hit), 32'(hit));
            checkOutput("bready", 32'(axi.bready), 32'(b_pending));
            b_hs = b_pending && axi.bvalid;
            checkOutput("bus_err", 32'(bus_err), 32'(b_hs && axi.bresp != 2'b00));
            if (prev_aw_stall) begin
                checkOutput("aw_hold_valid", 32'(axi.awvalid), 32'h1);
                checkOutput("aw_hold_addr", axi.awaddr, prev_awaddr);
            end
            if (prev_w_stall) begin
                checkOutput("w_hold_valid", 32'(axi.wvalid), 32'h1);
                checkOutput("w_hold_data", axi.wdata, prev_wdata);
            end
            if (q.size() == 0 || aw_seen) begin
                checkOutput("awvalid_unexpected", 32'(axi.awvalid), 32'h0);
            end else if (axi.awvalid) begin
                checkOutput("awaddr", axi.awaddr, q[0].addr);
                checkOutput("awsize", 32'(axi.awsize), 32'(q[0].size));
                checkOutput("awid", 32'(axi.awid), 32'h1);
                checkOutput("awlen", 32'(axi.awlen), 32'h0);
                checkOutput("awburst", 32'(axi.awburst), 32'h1);
                checkOutput("aw_lock_cache_prot",
                            32'({axi.awlock, axi.awcache, axi.awprot}), 32'h0);
            end
            if (q.size() == 0 || w_seen) begin
                checkOutput("wvalid_unexpected", 32'(axi.wvalid), 32'h0);
            end else if (axi.wvalid) begin
                checkOutput("wdata", axi.wdata, q[0].data);
                checkOutput("wstrb", 32'(axi.wstrb), 32'(q[0].strb));
                checkOutput("wid", 32'(axi.wid), 32'h1);
                checkOutput("wlast", 32'(axi.wlast), 32'h1);
            end

            if (axi.awvalid && axi.awready) begin
                aw_seen = 1;
                aw_total++;
            end
            if (axi.wvalid && axi.wready) begin
                w_seen = 1;
                w_total++;
            end
            if (b_hs) begin
                if (q.size() > 0) void'(q.pop_front());
                pops++;
                aw_seen   = 0;
                w_seen    = 0;
                b_pending = 0;
            end else if (aw_seen && w_seen) begin
                b_pending = 1;
            end
            if (in_valid && can_push) begin
                q.push_back('{addr: in_addr, data: in_data, strb: in_strb, size: in_size});
            end
            prev_aw_stall = axi.awvalid && !axi.awready;
            prev_awaddr   = axi.awaddr;
            prev_w_stall  = axi.wvalid && !axi.wready;
            prev_wdata    = axi.wdata;
        end
    end

    initial begin : watchdog
        #500000;
        failures++;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int last, n, aw0, w0, p0, err_cnt;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.bid     = 4'd1;

        // Reset values
        repeat (2) @(posedge aclk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
        checkOutput("rst_empty", 32'(empty), 32'h1);
        checkOutput("rst_count", 32'(count), 32'h0);
        checkOutput("rst_valids_bready", 32'({axi.awvalid, axi.wvalid, axi.bready}), 32'h0);
        checkOutput("rst_bus_err", 32'(bus_err), 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;

        // Single store through a zero-wait slave; awvalid on the second cycle
        applyStimulus(1'b1, 32'h1FAF_F000, 32'hDEAD_BEEF, 4'hF, 3'd2);
        idleCycle();
        @(negedge aclk);
        checkOutput("lat_awvalid_cycle1", 32'(axi.awvalid), 32'h0);
        idleCycle();
        @(negedge aclk);
        checkOutput("lat_awvalid_cycle2", 32'(axi.awvalid), 32'h1);
        checkOutput("single_awaddr", axi.awaddr, 32'h1FAF_F000);
        checkOutput("single_wdata", axi.wdata, 32'hDEAD_BEEF);
        checkOutput("single_awsize", 32'(axi.awsize), 32'h2);
        waitEmpty(50, "single_drain");

        // Fill with AW stalled, then drain in order
        slv_awready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h0000_2000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 3'd2);
        end
        applyStimulus(1'b1, 32'h0000_2040, 32'hBAD0_0000, 4'hF, 3'd2);
        @(negedge aclk);
        checkOutput("fill_in_ready", 32'(in_ready), 32'h0);
        checkOutput("fill_count", 32'(count), 32'h4);
        slv_awready = 1'b1;
        last = 4;
        n = 0;
        while (last != 0 && n < 100) begin
            idleCycle();
            @(negedge aclk);
            if (32'(count) != last) begin
                checkOutput("fill_count_step", 32'(count), 32'(last - 1));
                last = 32'(count);
            end
            n++;
        end
        checkOutput("fill_drained", 32'(count), 32'h0);
        waitEmpty(20, "fill_empty");

        // W accepted well before AW, then AW well before W
        aw0 = aw_total;
        w0  = w_total;
        slv_awready = 1'b0;
        slv_wready  = 1'b1;
        applyStimulus(1'b1, 32'h0000_4000, 32'h1111_1111, 4'h3, 3'd1);
        repeat (5) idleCycle();
        slv_awready = 1'b1;
        waitEmpty(30, "order_w_first_drain");
        slv_wready = 1'b0;
        applyStimulus(1'b1, 32'h0000_4004, 32'h2222_2222, 4'hC, 3'd1);
        repeat (5) idleCycle();
        slv_wready = 1'b1;
        waitEmpty(30, "order_aw_first_drain");
        checkOutput("order_aw_count", 32'(aw_total - aw0), 32'h2);
        checkOutput("order_w_count", 32'(w_total - w0), 32'h2);

        // Load hazard against a pending store
        slv_awready = 1'b0;
        next_chk = 32'h0000_1006;
        applyStimulus(1'b1, 32'h0000_1004, 32'h5555_AAAA, 4'hF, 3'd2);
        idleCycle();
        @(negedge aclk);
        checkOutput("hazard_same_word", 32'(chk_hit), 32'h1);
        next_chk = 32'h0000_1008;
        idleCycle();
        @(negedge aclk);
        checkOutput("hazard_next_word", 32'(chk_hit), 32'h0);
        next_chk = 32'h0000_1006;
        slv_awready = 1'b1;
        n = 0;
        while (!(axi.bvalid && axi.bready) && n < 30) begin
            idleCycle();
            @(negedge aclk);
            n++;
        end
        checkOutput("hazard_b_seen", 32'(axi.bvalid && axi.bready), 32'h1);
        checkOutput("hazard_hold_at_b", 32'(chk_hit), 32'h1);
        idleCycle();
        @(negedge aclk);
        checkOutput("hazard_clear_after_b", 32'(chk_hit), 32'h0);
        waitEmpty(10, "hazard_drain");

        // Error response on the second of three stores
        p0 = pops;
        err_at = p0 + 1;
        err_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h0000_5000 + 32'(i * 4), 32'hE000_0000 + 32'(i), 4'hF, 3'd2);
            @(negedge aclk);
            if (bus_err) err_cnt++;
        end
        n = 0;
        while (n < 60) begin
            idleCycle();
            @(negedge aclk);
            if (bus_err) err_cnt++;
            if (empty && q.size() == 0) break;
            n++;
        end
        checkOutput("err_pulses", 32'(err_cnt), 32'h1);
        checkOutput("err_all_drained", 32'(pops - p0), 32'h3);
        err_at = -1;

        // Asynchronous reset while waiting for B with three entries
        slv_bv_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h0000_6000 + 32'(i * 4), 32'h6000_0000 + 32'(i), 4'hF, 3'd2);
        end
        n = 0;
        while (!(axi.bready === 1'b1) && n < 30) begin
            idleCycle();
            @(negedge aclk);
            n++;
        end
        checkOutput("rst_mid_in_wait_b", 32'(axi.bready), 32'h1);
        checkOutput("rst_mid_count", 32'(count), 32'h3);
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        checkOutput("rst_mid_valids_bready", 32'({axi.awvalid, axi.wvalid, axi.bready}), 32'h0);
        checkOutput("rst_mid_empty", 32'(empty), 32'h1);
        checkOutput("rst_mid_count_zero", 32'(count), 32'h0);
        @(negedge aclk);
        @(negedge aclk);
        aresetn   = 1'b1;
        slv_bv_en = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            slv_awready = 1'($urandom % 4 != 0);
            slv_wready  = 1'($urandom % 4 != 0);
            slv_bv_en   = 1'($urandom % 3 != 0);
            slv_bresp   = ($urandom % 4 == 0) ? 2'b10 : 2'b00;
            next_chk    = 32'h0000_3000 + 32'(($urandom % 8) * 4) + 32'($urandom % 4);
            applyStimulus(1'($urandom % 2),
                          32'h0000_3000 + 32'(($urandom % 8) * 4),
                          $urandom, 4'($urandom), 3'($urandom % 3));
        end
        slv_awready = 1'b1;
        slv_wready  = 1'b1;
        slv_bv_en   = 1'b1;
        slv_bresp   = 2'b00;
        waitEmpty(200, "random_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
